disp_num: RTL and testbench

Four-digit multiplexed seven-segment driver for the game's score readout. It takes a 16-bit hex value, per-digit blanking and decimal-point masks, and scans the four digits in turn. Digit select and segment outputs are active-low, matching the board's common-anode display. It sits beside the VGA pipeline in the top-level display path and owns its own free-running `clkdiv` counter.

---
 rtl/disp_pkg.sv | 26 ++
 rtl/disp_num_clkdiv.sv | 32 +++
 rtl/disp_num.sv | 70 +++++++
 tb/tb_disp_num.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the four-digit seven-segment score readout.
//   - SCAN_BIT_DEFAULT : default clkdiv bit used as the low digit-select bit
//   - SEG_*            : bit positions inside the 8-bit Segment bus {dp,g,f,e,d,c,b,a}
//   - HEX_SEG_LUT      : active-low gfedcba pattern for each hex nibble
`timescale 1ns/1ps
package disp_pkg;

    localparam int SCAN_BIT_DEFAULT = 17;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Common-anode display: a 0 lights the segment.
    localparam logic [6:0] HEX_SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_LUT[nibble];
    endfunction

endpackage

// File: rtl/disp_num_clkdiv.sv
// Free-running 32-bit divider counter for the display path.
// Ports:
//   clk    : system clock
//   rstn   : asynchronous active-low reset, clears the counter
//   clkdiv : counter value, +1 per clock, wraps FFFF_FFFF -> 0
`timescale 1ns/1ps
module clkdiv (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] clkdiv
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Natural modulo-2^32 wrap; no terminal-count logic needed.
    assign cnt_d = cnt_q + 32'd1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the reset branch is in the sensitivity list so it acts
    // immediately, not on the next clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clkdiv = cnt_q;

endmodule

// File: rtl/disp_num.sv
// Four-digit multiplexed seven-segment driver (common-anode, active-low).
// Parameters:
//   SCAN_BIT : clkdiv[SCAN_BIT+1:SCAN_BIT] selects the digit; dwell = 2^SCAN_BIT clocks
// Ports:
//   clk     : system clock
//   rstn    : asynchronous active-low reset; blanks the display and clears the counter
//   HEXS    : 16-bit value, digit k shows HEXS[4k+3:4k]
//   LES     : per-digit blank, 1 = digit dark
//   points  : per-digit decimal point, 1 = dp lit
//   AN      : digit anodes, active-low, one-hot-zero (registered)
//   Segment : {dp,g,f,e,d,c,b,a}, active-low (registered)
//   clkdiv  : free-running divider counter, shared with other display logic
`timescale 1ns/1ps
module disp_num
    import disp_pkg::*;
#(
    parameter int SCAN_BIT = SCAN_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] HEXS,
    input  logic [3:0]  LES,
    input  logic [3:0]  points,
    output logic [3:0]  AN,
    output logic [7:0]  Segment,
    output logic [31:0] clkdiv
);

    logic [1:0] scan_idx;
    logic [3:0] nibble;
    logic [3:0] an_d;
    logic [3:0] an_q;
    logic [7:0] seg_d;
    logic [7:0] seg_q;

    clkdiv u_clkdiv (
        .clk    (clk),
        .rstn   (rstn),
        .clkdiv (clkdiv)
    );

    // The counter wraps at a power of two, so the 2-bit digit index simply
    // rolls 3 -> 0 across a wrap with no special handling.
    assign scan_idx = clkdiv[SCAN_BIT+1 -: 2];

    // NOTE: every signal assigned here gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        an_d   = ~(4'b0001 << scan_idx);
        nibble = HEXS[{scan_idx, 2'b00} +: 4];
        seg_d  = 8'hFF;
        seg_d[SEG_DP] = ~points[scan_idx];
        // Blanking darkens only the digit segments; anode and dp are unaffected.
        seg_d[SEG_G:SEG_A] = LES[scan_idx] ? 7'h7F : hex_to_seg(nibble);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an_q  <= 4'hF;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign AN      = an_q;
    assign Segment = seg_q;

endmodule

// File: tb/tb_disp_num.sv
`timescale 1ns/1ps
module tb_disp_num;

    logic        clk;
    logic        rstn;
    logic [15:0] HEXS;
    logic [3:0]  LES;
    logic [3:0]  points;
    logic [3:0]  AN;
    logic [7:0]  Segment;
    logic [31:0] clkdiv;

    int total = 0;
    int bad   = 0;

    disp_num #(.SCAN_BIT(2)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .HEXS    (HEXS),
        .LES     (LES),
        .points  (points),
        .AN      (AN),
        .Segment (Segment),
        .clkdiv  (clkdiv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent copy of the active-low gfedcba table.
    logic [6:0] seg_ref [16];

    typedef struct {
        string       name;
        logic [15:0] hexs;
        logic [3:0]  les;
        logic [3:0]  pts;
        int          digit;
        logic [3:0]  exp_an;
        logic [7:0]  exp_seg;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (5) step();
        rstn = 1'b1;
    endtask

    logic [3:0] scan_an  [4];
    logic [7:0] beef_seg [4];

    initial begin
        seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        scan_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        beef_seg = '{8'h8E, 8'h86, 8'h86, 8'h83};

        // Table: all 16 nibbles on digit 0, then blank/dp combinations.
        for (int i = 0; i < 16; i++) begin
            vec_t v;
            v.name    = $sformatf("hex_%0h", i);
            v.hexs    = 16'hA5C0 | 16'(i);
            v.les     = 4'b0000;
            v.pts     = 4'b0000;
            v.digit   = 0;
            v.exp_an  = 4'hE;
            v.exp_seg = {1'b1, seg_ref[i]};
            vecs.push_back(v);
        end
        vecs.push_back('{"blank_dp_d0", 16'h8888, 4'b0010, 4'b0101, 0, 4'hE, 8'h00});
        vecs.push_back('{"blank_dp_d1", 16'h8888, 4'b0010, 4'b0101, 1, 4'hD, 8'hFF});
        vecs.push_back('{"blank_dp_d2", 16'h8888, 4'b0010, 4'b0101, 2, 4'hB, 8'h00});
        vecs.push_back('{"blank_dp_d3", 16'h8888, 4'b0010, 4'b0101, 3, 4'h7, 8'h80});

        // Reset state and first digit after release.
        rstn   = 1'b0;
        HEXS   = 16'h1234;
        LES    = 4'b0000;
        points = 4'b0000;
        repeat (5) step();
        check("rst_an", 32'(AN), 32'h0000_000F);
        check("rst_seg", 32'(Segment), 32'h0000_00FF);
        check("rst_cnt", clkdiv, 32'd0);
        rstn = 1'b1;
        step();
        check("first_an", 32'(AN), 32'h0000_000E);
        check("first_seg", 32'(Segment), 32'h0000_0099);
        check("first_cnt", clkdiv, 32'd1);

        // Full scan over two frames.
        HEXS = 16'hBEEF;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            step();
            check($sformatf("scan_an_%0d", k), 32'(AN), 32'(scan_an[(k / 4) % 4]));
            check($sformatf("scan_seg_%0d", k), 32'(Segment), 32'(beef_seg[(k / 4) % 4]));
        end

        // Table-driven vectors.
        foreach (vecs[i]) begin
            HEXS   = vecs[i].hexs;
            LES    = vecs[i].les;
            points = vecs[i].pts;
            do_reset();
            repeat (4 * vecs[i].digit + 1) step();
            check({vecs[i].name, "_an"}, 32'(AN), 32'(vecs[i].exp_an));
            check({vecs[i].name, "_seg"}, 32'(Segment), 32'(vecs[i].exp_seg));
        end

        // Live input change on the current digit reaches the outputs in one clock.
        HEXS = 16'h0000; LES = 4'b0000; points = 4'b0000;
        do_reset();
        step();
        check("live_before", 32'(Segment), 32'h0000_00C0);
        HEXS[3:0] = 4'h7;
        points[0] = 1'b1;
        step();
        check("live_after", 32'(Segment), 32'h0000_0078);

        // Asynchronous reset in the middle of digit 2.
        HEXS = 16'hBEEF; points = 4'b0000;
        do_reset();
        repeat (9) step();
        check("mid_pre_an", 32'(AN), 32'h0000_000B);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_an", 32'(AN), 32'h0000_000F);
        check("mid_rst_seg", 32'(Segment), 32'h0000_00FF);
        check("mid_rst_cnt", clkdiv, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        check("mid_restart_an", 32'(AN), 32'h0000_000E);
        check("mid_restart_seg", 32'(Segment), 32'h0000_008E);

        // Counter wrap: scan continues 3 -> 0.
        force dut.u_clkdiv.cnt_q = 32'hFFFF_FFFE;
        #1 release dut.u_clkdiv.cnt_q;
        step();
        check("wrap_an_a", 32'(AN), 32'h0000_0007);
        check("wrap_cnt_a", clkdiv, 32'hFFFF_FFFF);
        step();
        check("wrap_an_b", 32'(AN), 32'h0000_0007);
        check("wrap_cnt_b", clkdiv, 32'd0);
        step();
        check("wrap_an_c", 32'(AN), 32'h0000_000E);
        check("wrap_seg_c", 32'(Segment), 32'h0000_008E);
        check("wrap_cnt_c", clkdiv, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
